extram_sram_responder: RTL

- Target-side responder for the CPU's external-RAM bus: accepts 32-bit read/write requests with byte strobes.
- Serves each request from an asynchronous 16-bit SRAM using two half-word accesses, then returns a one-cycle ready pulse.
- Sits between the CPU wrapper's external-RAM port and the board SRAM pins.
- Adds the wait-state handshake that a zero-wait-state bus cannot provide.

---
 rtl/extram_pkg.sv | 26 ++
 rtl/extram_sram_responder_if.sv | 31 +++
 rtl/extram_sram_responder_read_buffer.sv | 42 ++++
 rtl/extram_sram_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/extram_pkg.sv
// extram_pkg: shared types and constants for the external-RAM SRAM responder.
//   state_e       responder FSM state encoding (also exported on dbg_state)
//   *_ADDR_W      byte / half-word / word address widths
//   WAIT_*/TURN_* legal ranges of the WAIT_CYCLES / TURNAROUND parameters
package extram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int BYTE_ADDR_W = 16;
  localparam int HALF_ADDR_W = 15;
  localparam int WORD_ADDR_W = 14;
  localparam int DATA_W      = 32;
  localparam int HALF_W      = 16;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int TURN_MIN = 0;
  localparam int TURN_MAX = 3;

endpackage

// File: rtl/extram_sram_responder_if.sv
// extram_sram_responder_if: CPU-side external-RAM request/response bus.
//   bus_valid/bus_addr/bus_wdata/bus_wstrb  request from the CPU wrapper
//   bus_rdata/bus_ready                     response from the responder
// Modports: master (CPU wrapper side), slave (responder side).
//
// Handshake: the master raises bus_valid with a stable request and holds it
// until it sees bus_ready. bus_ready is a single-cycle completion pulse; the
// request is consumed when bus_valid is seen in IDLE, not when bus_ready is
// high. bus_wstrb == 0 encodes a read. bus_rdata is valid in the bus_ready
// cycle and holds until the next request is accepted.
interface extram_sram_responder_if;
  import extram_pkg::*;

  logic                   bus_valid;
  logic [BYTE_ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0]      bus_wdata;
  logic [3:0]             bus_wstrb;
  logic [DATA_W-1:0]      bus_rdata;
  logic                   bus_ready;

  modport master (
    output bus_valid, bus_addr, bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/extram_sram_responder_read_buffer.sv
// extram_read_buffer: single-entry {valid, word address, data} read cache.
//   lookup_addr/hit/hit_data  combinational tag compare against the entry
//   fill_en/fill_addr/fill_data   load the entry after a completed read
//   inval_en/inval_addr           drop the entry when a write hits its word
// Fill has priority over invalidate; both never occur in the same cycle.
module extram_read_buffer
  import extram_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_ADDR_W-1:0] lookup_addr,
  output logic                   hit,
  output logic [DATA_W-1:0]      hit_data,
  input  logic                   fill_en,
  input  logic [WORD_ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0]      fill_data,
  input  logic                   inval_en,
  input  logic [WORD_ADDR_W-1:0] inval_addr
);

  logic                   valid_q;
  logic [WORD_ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0]      data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr;
      data_q  <= fill_data;
    end else if (inval_en && (inval_addr == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/extram_sram_responder.sv
// extram_sram_responder: serves 32-bit external-RAM bus requests from an
// asynchronous 16-bit SRAM with two half-word accesses and a ready pulse.
// Parameters: WAIT_CYCLES (1..15) cycles per half with OE_n/WE_n low;
//             TURNAROUND  (0..3)  all-strobes-high cycles between halves.
// Ports: clk, rst (async, active high); bus (slave modport of
//   extram_sram_responder_if); sram_a/sram_dq_out/sram_dq_in/sram_dq_oe and
//   active-low strobes sram_ce_n/oe_n/we_n/lb_n/ub_n; dbg_state (FSM state).
// Build option: EXTRAM_SRAM_RESPONDER_READ_BUFFER_EN adds a one-entry read
//   buffer so repeated reads of the same word skip the SRAM.
module extram_sram_responder
  import extram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int TURNAROUND  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  extram_sram_responder_if.slave bus,
  output logic [HALF_ADDR_W-1:0] sram_a,
  output logic [HALF_W-1:0]      sram_dq_out,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_lb_n,
  output logic                   sram_ub_n,
  output state_e                 dbg_state
);

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX ||
      TURNAROUND < TURN_MIN || TURNAROUND > TURN_MAX) begin : g_bad_param
    $error("extram_sram_responder: WAIT_CYCLES/TURNAROUND out of range");
  end

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  state_e                 state_q, state_d;
  logic                   half_q, half_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   is_read;
  logic                   unused_addr_lsb;

  assign is_read         = (wstrb_q == 4'b0000);
  assign unused_addr_lsb = ^bus.bus_addr[1:0];

`ifdef EXTRAM_SRAM_RESPONDER_READ_BUFFER_EN
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              fill_en, inval_en;

  extram_read_buffer u_read_buffer (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (bus.bus_addr[BYTE_ADDR_W-1:2]),
    .hit         (buf_hit),
    .hit_data    (buf_data),
    .fill_en     (fill_en),
    .fill_addr   (addr_q),
    .fill_data   ({sram_dq_in, rdata_q[HALF_W-1:0]}),
    .inval_en    (inval_en),
    .inval_addr  (bus.bus_addr[BYTE_ADDR_W-1:2])
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
`ifdef EXTRAM_SRAM_RESPONDER_READ_BUFFER_EN
    fill_en  = 1'b0;
    inval_en = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.bus_valid) begin
          addr_d  = bus.bus_addr[BYTE_ADDR_W-1:2];
          wdata_d = bus.bus_wdata;
          wstrb_d = bus.bus_wstrb;
          cnt_d   = '0;
          // A write that touches only the upper bytes skips the low half.
          half_d  = (bus.bus_wstrb != 4'b0000) && (bus.bus_wstrb[1:0] == 2'b00);
          state_d = ST_SETUP;
`ifdef EXTRAM_SRAM_RESPONDER_READ_BUFFER_EN
          inval_en = (bus.bus_wstrb != 4'b0000);
          if ((bus.bus_wstrb == 4'b0000) && buf_hit) begin
            rdata_d = buf_data;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          if (is_read) begin
            if (half_q) rdata_d[DATA_W-1:HALF_W] = sram_dq_in;
            else        rdata_d[HALF_W-1:0]      = sram_dq_in;
          end
          cnt_d = '0;
          if (!half_q && (is_read || (wstrb_q[3:2] != 2'b00))) begin
            if (TURNAROUND == 0) begin
              half_d  = 1'b1;
              state_d = ST_SETUP;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_DONE;
`ifdef EXTRAM_SRAM_RESPONDER_READ_BUFFER_EN
            fill_en = is_read;
`endif
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == TURN_LAST) begin
          half_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // SRAM pins decode from registered state only, so address and write
    // data stay put from SETUP until the next half (or next request).
    sram_a      = {addr_q, half_q};
    sram_dq_out = half_q ? wdata_q[DATA_W-1:HALF_W] : wdata_q[HALF_W-1:0];
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_lb_n   = 1'b1;
    sram_ub_n   = 1'b1;
    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
      sram_ce_n  = 1'b0;
      sram_dq_oe = !is_read;
      if (is_read) begin
        sram_lb_n = 1'b0;
        sram_ub_n = 1'b0;
      end else begin
        sram_lb_n = half_q ? !wstrb_q[2] : !wstrb_q[0];
        sram_ub_n = half_q ? !wstrb_q[3] : !wstrb_q[1];
      end
      if (state_q == ST_ACCESS) begin
        sram_oe_n = !is_read;
        sram_we_n = is_read;
      end
    end
  end

  assign bus.bus_ready = (state_q == ST_DONE);
  assign bus.bus_rdata = rdata_q;
  assign dbg_state     = state_q;

endmodule
